// File: rtl/mealy_machine.sv
// Overlapping 0-1-0-1 serial pattern detector, 4-state Mealy FSM.
// Optional saturating match counter enabled by defining MEALY_MATCH_CNT_EN.
module mealy_machine (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       out
`ifdef MEALY_MATCH_CNT_EN
    ,
    output logic [7:0] match_count
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t current_state;
    state_t next_state;

    // Next state: each state is the longest prefix of 0101 seen so far.
    always_comb begin
        next_state = S0;
        case (current_state)
            S0:      next_state = in ? S0 : S1;
            S1:      next_state = in ? S2 : S1;
            S2:      next_state = in ? S0 : S3;
            S3:      next_state = in ? S2 : S1;
            default: next_state = S0;
        endcase
    end

    // Detect flag is combinational so it flags the completing bit itself.
    assign out = (current_state == S3) && in;

    // State register, cleared immediately while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_state <= S0;
        end else begin
            current_state <= next_state;
        end
    end

`ifdef MEALY_MATCH_CNT_EN
    // Match counter sticks at 8'hFF instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_count <= 8'h00;
        end else if (out && (match_count != 8'hFF)) begin
            match_count <= match_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_mealy_machine.sv
// Randomized and directed bench for mealy_machine.
// Reference model tracks recent input history and matches it against 0101.
module tb_mealy_machine;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       out;
`ifdef MEALY_MATCH_CNT_EN
    logic [7:0] match_count;
`endif

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [2:0] hist;
    int         hlen;
    int         mcount;

    mealy_machine dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_bit),
        .out         (out)
`ifdef MEALY_MATCH_CNT_EN
        ,
        .match_count (match_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Length of the longest suffix of the history that is a prefix of 0101.
    function automatic int model_state();
        int h;
        h = int'(hist);
        for (int k = 3; k >= 1; k--) begin
            if (hlen >= k && ((h & ((1 << k) - 1)) == (5 >> (4 - k))))
                return k;
        end
        return 0;
    endfunction

    function automatic logic model_out(input logic b);
        int w;
        w = ((int'(hist) << 1) | int'(b)) & 15;
        return (hlen >= 3) && (w == 5);
    endfunction

    task automatic model_clear();
        hist = 3'b000;
        hlen = 0;
        mcount = 0;
    endtask

    task automatic count_check(input string tag);
`ifdef MEALY_MATCH_CNT_EN
        check(tag, 32'(match_count), 32'(mcount));
`endif
    endtask

    // Drive one bit, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic b);
        logic eo;
        in_bit = b;
        @(negedge clk);
        eo = model_out(b);
        check("state", 32'(dut.current_state), 32'(model_state()));
        check("out", 32'(out), 32'(eo));
        count_check("count");
        if (eo) pulses++;
        @(posedge clk);
        if (eo && mcount < 255) mcount++;
        hist = {hist[1:0], b};
        if (hlen < 3) hlen++;
        #1;
    endtask

    task automatic seq(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(v[i]);
    endtask

    // Called just after a rising edge; asserts reset mid-cycle.
    task automatic do_reset();
        #2 reset = 1'b0;
        in_bit = 1'b1;
        #1;
        check("rst_state", 32'(dut.current_state), 32'd0);
        check("rst_out", 32'(out), 32'd0);
`ifdef MEALY_MATCH_CNT_EN
        check("rst_count", 32'(match_count), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        pulses = 0;
    endtask

    initial begin
        reset  = 1'b0;
        in_bit = 1'b0;
        model_clear();
        #10;
        check("por_state", 32'(dut.current_state), 32'd0);
        check("por_out", 32'(out), 32'd0);
        in_bit = 1'b1;
        #1;
        check("por_out_in1", 32'(out), 32'd0);
`ifdef MEALY_MATCH_CNT_EN
        check("por_count", 32'(match_count), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic match
        seq(32'b0101, 4);
        check("basic_state", 32'(dut.current_state), 32'd2);
        check("basic_pulses", 32'(pulses), 32'd1);

        // Full transition coverage
        do_reset();
        seq(32'b01010011, 8);
        check("cov_final", 32'(dut.current_state), 32'd0);
        check("cov_pulses", 32'(pulses), 32'd1);

        // Overlap
        do_reset();
        seq(32'b010101, 6);
        check("ovl_pulses", 32'(pulses), 32'd2);

        // Non-matching
        do_reset();
        seq(32'b01101, 5);
        check("nomatch_pulses", 32'(pulses), 32'd0);

        // Reset then reuse
        do_reset();
        seq(32'b0110, 4);
        check("reuse_state", 32'(dut.current_state), 32'd1);
        check("reuse_pulses", 32'(pulses), 32'd0);

        // Reset asserted from S2 loses history
        do_reset();
        seq(32'b01, 2);
        check("pre_rst_s2", 32'(dut.current_state), 32'd2);
        do_reset();
        seq(32'b01, 2);
        check("post_rst_s2", 32'(dut.current_state), 32'd2);
        check("post_rst_pulses", 32'(pulses), 32'd0);

        // Counter: three overlapping matches, then saturation
        do_reset();
        seq(32'b01010101, 8);
        check("three_pulses", 32'(pulses), 32'd3);
        count_check("count_three");
        for (int i = 0; i < 300; i++) seq(32'b01, 2);
        check("sat_pulses", 32'(pulses), 32'd303);
        count_check("count_sat");
        do_reset();
        count_check("count_cleared");

        // Random stream
        for (int i = 0; i < 2000; i++) begin
            if ((i % 500) == 499) do_reset();
            step(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
